// File: rtl/multicycle_controller.sv
// Main control FSM for the multi-cycle RV32I datapath: sequences fetch/decode/execute/memory/writeback.
// Optional ILLEGAL_TRAP_EN: unknown opcodes and unsupported funct3 values lock the FSM in TRAP until reset.
module multicycle_controller #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [XLEN-1:0]    Instr,
  input  logic               N,
  input  logic               Z,
  input  logic               C,
  input  logic               V,
  output logic [2:0]         ImmSrc,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ResultSrc,
  output logic               AdrSrc,
  output logic [2:0]         ALUControl,
  output logic               IRWrite,
  output logic               PCWrite,
  output logic               RegWrite,
  output logic               MemWrite,
  output logic [STATE_W-1:0] State,
  output logic               Illegal
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    JAL      = 4'd10,
    JALR1    = 4'd11,
    JALR2    = 4'd12,
    TRAP     = 4'd13
  } state_t;

  localparam logic [6:0] OP_LW     = 7'b0000011;
  localparam logic [6:0] OP_SW     = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  state_t     state, state_next;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [2:0] alu_funct;
  logic       taken;
  logic       unused_bits;

  assign opcode      = Instr[6:0];
  assign funct3      = Instr[14:12];
  assign unused_bits = ^{Instr[31], Instr[29:15], Instr[11:7]};
  assign State       = STATE_W'(state);

  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= state_next;
  end

  // Unsupported ALU funct3 values fall back to add.
  always_comb begin
    alu_funct = 3'b000;
    case (funct3)
      3'b000:  alu_funct = (state == EXECUTER && Instr[30]) ? 3'b001 : 3'b000;
      3'b010:  alu_funct = 3'b101;
      3'b100:  alu_funct = 3'b100;
      3'b110:  alu_funct = 3'b011;
      3'b111:  alu_funct = 3'b010;
      default: alu_funct = 3'b000;
    endcase
  end

  always_comb begin
    taken = 1'b0;
    case (funct3)
      3'b000:  taken = Z;
      3'b001:  taken = !Z;
      3'b100:  taken = N ^ V;
      3'b101:  taken = !(N ^ V);
      3'b110:  taken = !C;
      3'b111:  taken = C;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    case (opcode)
      OP_SW:     ImmSrc = 3'b001;
      OP_BRANCH: ImmSrc = 3'b010;
      OP_JAL:    ImmSrc = 3'b011;
      default:   ImmSrc = 3'b000;
    endcase
  end

`ifdef ILLEGAL_TRAP_EN
  logic alu_ok, br_ok;
  assign alu_ok = (funct3 == 3'b000) || (funct3 == 3'b010) || (funct3 == 3'b100) ||
                  (funct3 == 3'b110) || (funct3 == 3'b111);
  assign br_ok  = (funct3[2:1] != 2'b01);
`endif

  always_comb begin
    state_next = state;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    AdrSrc     = 1'b0;
    ALUControl = 3'b000;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    RegWrite   = 1'b0;
    MemWrite   = 1'b0;
    Illegal    = 1'b0;
    case (state)
      FETCH: begin
        IRWrite    = 1'b1;
        ALUSrcB    = 2'b10;
        ResultSrc  = 2'b10;
        PCWrite    = 1'b1;
        state_next = DECODE;
      end
      DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (opcode)
          OP_LW, OP_SW: state_next = MEMADR;
          OP_R:         state_next = EXECUTER;
          OP_I:         state_next = EXECUTEI;
          OP_BRANCH:    state_next = BRANCH;
          OP_JAL:       state_next = JAL;
          OP_JALR:      state_next = JALR1;
`ifdef ILLEGAL_TRAP_EN
          default:      state_next = TRAP;
`else
          default:      state_next = FETCH;
`endif
        endcase
      end
      MEMADR: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        state_next = (opcode == OP_LW) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        AdrSrc     = 1'b1;
        state_next = MEMWB;
      end
      MEMWB: begin
        ResultSrc  = 2'b01;
        RegWrite   = 1'b1;
        state_next = FETCH;
      end
      MEMWRITE: begin
        AdrSrc     = 1'b1;
        MemWrite   = 1'b1;
        state_next = FETCH;
      end
      EXECUTER, EXECUTEI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = (state == EXECUTEI) ? 2'b01 : 2'b00;
        ALUControl = alu_funct;
`ifdef ILLEGAL_TRAP_EN
        state_next = alu_ok ? ALUWB : TRAP;
`else
        state_next = ALUWB;
`endif
      end
      ALUWB: begin
        RegWrite   = 1'b1;
        state_next = FETCH;
      end
      BRANCH: begin
        ALUSrcA    = 2'b10;
        ALUControl = 3'b001;
        PCWrite    = taken;
`ifdef ILLEGAL_TRAP_EN
        state_next = br_ok ? FETCH : TRAP;
`else
        state_next = FETCH;
`endif
      end
      JAL, JALR2: begin
        ALUSrcA    = 2'b01;
        ALUSrcB    = 2'b10;
        PCWrite    = 1'b1;
        state_next = ALUWB;
      end
      JALR1: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        state_next = JALR2;
      end
      TRAP: begin
`ifdef ILLEGAL_TRAP_EN
        Illegal    = 1'b1;
        state_next = TRAP;
`else
        state_next = FETCH;
`endif
      end
      default: state_next = FETCH;
    endcase
    if (reset) begin
      IRWrite  = 1'b0;
      PCWrite  = 1'b0;
      RegWrite = 1'b0;
      MemWrite = 1'b0;
      Illegal  = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: stimulus queues per-cycle expected outputs, a negedge monitor compares.
module tb_multicycle_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Instr;
  logic        N, Z, C, V;
  logic [2:0]  ImmSrc, ALUControl;
  logic [1:0]  ALUSrcA, ALUSrcB, ResultSrc;
  logic        AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite, Illegal;
  logic [3:0]  State;

  multicycle_controller #(.XLEN(32), .STATE_W(4)) dut (
    .clk(clk), .reset(reset), .Instr(Instr), .N(N), .Z(Z), .C(C), .V(V),
    .ImmSrc(ImmSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
    .AdrSrc(AdrSrc), .ALUControl(ALUControl), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .RegWrite(RegWrite), .MemWrite(MemWrite), .State(State), .Illegal(Illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic [2:0] imm;
    logic [1:0] a;
    logic [1:0] b;
    logic [1:0] res;
    logic       adr;
    logic [2:0] alu;
    logic       irw;
    logic       pcw;
    logic       rw;
    logic       mw;
    logic       ill;
  } vec_t;

  typedef struct {
    vec_t  v;
    string tag;
  } item_t;

  item_t q[$];
  int    checks = 0;
  int    errors = 0;

  // Expected outputs of each state, written out from the state action table.
  function automatic vec_t ex(input logic [3:0] st, input logic [2:0] imm);
    vec_t e;
    e = '0;
    e.st  = st;
    e.imm = imm;
    case (st)
      4'd0:  begin e.b = 2'b10; e.res = 2'b10; e.irw = 1'b1; e.pcw = 1'b1; end
      4'd1:  begin e.a = 2'b01; e.b = 2'b01; end
      4'd2:  begin e.a = 2'b10; e.b = 2'b01; end
      4'd3:  begin e.adr = 1'b1; end
      4'd4:  begin e.res = 2'b01; e.rw = 1'b1; end
      4'd5:  begin e.adr = 1'b1; e.mw = 1'b1; end
      4'd6:  begin e.a = 2'b10; end
      4'd7:  begin e.a = 2'b10; e.b = 2'b01; end
      4'd8:  begin e.rw = 1'b1; end
      4'd9:  begin e.a = 2'b10; e.alu = 3'b001; end
      4'd10: begin e.a = 2'b01; e.b = 2'b10; e.pcw = 1'b1; end
      4'd11: begin e.a = 2'b10; e.b = 2'b01; end
      4'd12: begin e.a = 2'b01; e.b = 2'b10; e.pcw = 1'b1; end
      4'd13: begin e.ill = 1'b1; end
      default: ;
    endcase
    return e;
  endfunction

  task automatic cyc(input vec_t v, input string tag);
    q.push_back('{v: v, tag: tag});
    @(posedge clk);
    #1;
  endtask

  task automatic run(input logic [3:0] st, input logic [2:0] imm, input string tag);
    cyc(ex(st, imm), tag);
  endtask

  task automatic alu_instr(input logic [31:0] ins, input logic [3:0] exst,
                           input logic [2:0] alu, input string tag);
    vec_t e;
    Instr = ins;
    run(4'd0, 3'b000, tag);
    run(4'd1, 3'b000, tag);
    e = ex(exst, 3'b000);
    e.alu = alu;
    cyc(e, tag);
    run(4'd8, 3'b000, tag);
  endtask

  task automatic branch(input logic [31:0] ins, input logic [3:0] flags,
                        input logic tk, input string tag);
    vec_t e;
    Instr = ins;
    {N, Z, C, V} = flags;
    run(4'd0, 3'b010, tag);
    run(4'd1, 3'b010, tag);
    e = ex(4'd9, 3'b010);
    e.pcw = tk;
    cyc(e, tag);
    {N, Z, C, V} = 4'b0000;
  endtask

  // One reset cycle from state st: write enables and Illegal forced low.
  task automatic reset_from(input logic [3:0] st, input logic [2:0] imm, input string tag);
    vec_t e;
    e = ex(st, imm);
    e.irw = 1'b0; e.pcw = 1'b0; e.rw = 1'b0; e.mw = 1'b0; e.ill = 1'b0;
    reset = 1'b1;
    cyc(e, tag);
    reset = 1'b0;
  endtask

  always @(negedge clk) begin
    item_t it;
    vec_t  act;
    if (q.size() > 0) begin
      it  = q.pop_front();
      act = '{st: State, imm: ImmSrc, a: ALUSrcA, b: ALUSrcB, res: ResultSrc, adr: AdrSrc,
              alu: ALUControl, irw: IRWrite, pcw: PCWrite, rw: RegWrite, mw: MemWrite,
              ill: Illegal};
      checks++;
      if (act !== it.v) begin
        errors++;
        $display("FAIL %s: state=%0d actual=%h required=%h (st imm a b res adr alu irw pcw rw mw ill)",
                 it.tag, State, act, it.v);
      end
      checks++;
      if ((RegWrite && MemWrite) || (IRWrite && State != 4'd0)) begin
        errors++;
        $display("FAIL invariant_%s: state=%0d RegWrite=%b MemWrite=%b IRWrite=%b required exclusive/FETCH-only",
                 it.tag, State, RegWrite, MemWrite, IRWrite);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t e;
    reset = 1'b1;
    Instr = 32'h00500093;
    {N, Z, C, V} = 4'b0000;
    @(posedge clk);
    #1;
    e = ex(4'd0, 3'b000);
    e.irw = 1'b0; e.pcw = 1'b0;
    cyc(e, "reset1");
    cyc(e, "reset2");
    reset = 1'b0;

    alu_instr(32'h00500093, 4'd7, 3'b000, "addi");

    Instr = 32'h0040A103;
    run(4'd0, 3'b000, "lw"); run(4'd1, 3'b000, "lw"); run(4'd2, 3'b000, "lw");
    run(4'd3, 3'b000, "lw"); run(4'd4, 3'b000, "lw");

    Instr = 32'h0020A223;
    run(4'd0, 3'b001, "sw"); run(4'd1, 3'b001, "sw"); run(4'd2, 3'b001, "sw");
    run(4'd5, 3'b001, "sw");

    branch(32'h00208463, 4'b0100, 1'b1, "beq_taken");
    branch(32'h00208463, 4'b0000, 1'b0, "beq_not");
    branch(32'h00209463, 4'b0000, 1'b1, "bne_taken");
    branch(32'h0020C463, 4'b1000, 1'b1, "blt_taken");
    branch(32'h0020D463, 4'b1001, 1'b1, "bge_nv");
    branch(32'h0020E463, 4'b0010, 1'b0, "bltu_not");
    branch(32'h0020F463, 4'b0010, 1'b1, "bgeu_taken");

    alu_instr(32'h402081B3, 4'd6, 3'b001, "sub");
    alu_instr(32'h002081B3, 4'd6, 3'b000, "add");
    alu_instr(32'h0020F1B3, 4'd6, 3'b010, "and");
    alu_instr(32'h0020E1B3, 4'd6, 3'b011, "or");
    alu_instr(32'h0020A1B3, 4'd6, 3'b101, "slt");
    alu_instr(32'h40008093, 4'd7, 3'b000, "addi_bit30");
    alu_instr(32'h0040C093, 4'd7, 3'b100, "xori");

    Instr = 32'h008000EF;
    run(4'd0, 3'b011, "jal"); run(4'd1, 3'b011, "jal"); run(4'd10, 3'b011, "jal");
    run(4'd8, 3'b011, "jal");

    Instr = 32'h000080E7;
    run(4'd0, 3'b000, "jalr"); run(4'd1, 3'b000, "jalr"); run(4'd11, 3'b000, "jalr");
    run(4'd12, 3'b000, "jalr"); run(4'd8, 3'b000, "jalr");

    Instr = 32'h0020A223;
    run(4'd0, 3'b001, "rst_mid"); run(4'd1, 3'b001, "rst_mid");
    reset_from(4'd2, 3'b001, "rst_mid");
    alu_instr(32'h00500093, 4'd7, 3'b000, "after_rst");

`ifdef ILLEGAL_TRAP_EN
    Instr = 32'h0000007F;
    run(4'd0, 3'b000, "illegal"); run(4'd1, 3'b000, "illegal");
    for (int i = 0; i < 10; i++) run(4'd13, 3'b000, "trap_hold");
    reset_from(4'd13, 3'b000, "trap_rst");

    Instr = 32'h00109093;
    run(4'd0, 3'b000, "slli"); run(4'd1, 3'b000, "slli"); run(4'd7, 3'b000, "slli");
    run(4'd13, 3'b000, "slli_trap");
    reset_from(4'd13, 3'b000, "slli_rst");

    Instr = 32'h0020A463;
    Z = 1'b1;
    run(4'd0, 3'b010, "br010"); run(4'd1, 3'b010, "br010"); run(4'd9, 3'b010, "br010");
    run(4'd13, 3'b010, "br010_trap");
    reset_from(4'd13, 3'b010, "br010_rst");
    Z = 1'b0;
`else
    Instr = 32'h0000007F;
    run(4'd0, 3'b000, "illegal"); run(4'd1, 3'b000, "illegal");
    alu_instr(32'h00109093, 4'd7, 3'b000, "slli_add");
    branch(32'h0020A463, 4'b0100, 1'b0, "br010_not");
`endif
    Instr = 32'h00500093;
    run(4'd0, 3'b000, "final_fetch");

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Main control FSM for the 32-bit multi-cycle RV32I datapath.
- Sequences fetch, decode, execute, memory and writeback by driving every datapath select and write enable, plus the memory write strobe.
- Decodes `Instr` from the instruction register and consumes the ALU flags N/Z/C/V.
- Instantiated beside the datapath in the CPU top; shares `clk` and `reset` with it.

Parameters:
- XLEN, 32, width of `Instr`; only 32 is supported.
- STATE_W, 4, width of the `State` debug output.

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- reset  in  1  synchronous, active-high reset
- Instr  in  XLEN  current instruction-register contents
- N, Z, C, V  in  1 each  combinational ALU flags from the current cycle
- ImmSrc  out  3  immediate format: 000 I, 001 S, 010 B, 011 J
- ALUSrcA  out  2  00 PC, 01 OldPC, 10 A
- ALUSrcB  out  2  00 WriteData, 01 ImmExt, 10 constant 4
- ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult
- AdrSrc  out  1  0 PC, 1 Result
- ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt
- IRWrite, PCWrite, RegWrite, MemWrite  out  1 each  write enables
- State  out  STATE_W  current FSM state (debug)
- Illegal  out  1  illegal-instruction flag (see Optional Feature)

Behaviour:
- **Reset.** One clock; reset is synchronous and active-high (ports `clk`, `reset`). The state register loads FETCH. While `reset`=1, PCWrite, IRWrite, RegWrite, MemWrite and Illegal are forced to 0. Reset mid-instruction abandons the instruction; no write enable pulses.
- **Output timing.** Outputs are a Moore decode of the state. Exceptions: PCWrite in BRANCH, ALUControl in EXECUTER/EXECUTEI, and ImmSrc also decode `Instr`. Signals not listed for a state are 0; selects default to 00.
- **Opcodes:** lw 0000011, sw 0100011, R 0110011, I-ALU 0010011, branch 1100011, jal 1101111, jalr 1100111.
- **State encoding and actions:**
  - FETCH=0: AdrSrc=0; IRWrite=1; A=00, B=10, add; ResultSrc=10; PCWrite=1 → DECODE.
  - DECODE=1: A=01, B=01, add (branch/jal target into ALUOut).
    - lw/sw → MEMADR; R → EXECUTER; I-ALU → EXECUTEI; branch → BRANCH; jal → JAL; jalr → JALR1.
    - Any other opcode → illegal handling.
  - MEMADR=2: A=10, B=01, add → MEMREAD (lw) or MEMWRITE (sw).
  - MEMREAD=3: ResultSrc=00, AdrSrc=1 → MEMWB.
  - MEMWB=4: ResultSrc=01, RegWrite=1 → FETCH.
  - MEMWRITE=5: ResultSrc=00, AdrSrc=1, MemWrite=1 → FETCH.
  - EXECUTER=6: A=10, B=00, ALUControl from funct → ALUWB.
  - EXECUTEI=7: A=10, B=01, ALUControl from funct → ALUWB.
  - ALUWB=8: ResultSrc=00, RegWrite=1 → FETCH.
  - BRANCH=9: A=10, B=00, sub; ResultSrc=00; PCWrite=taken → FETCH.
  - JAL=10: A=01, B=10, add; ResultSrc=00; PCWrite=1 → ALUWB (rd ← OldPC+4).
  - JALR1=11: A=10, B=01, add → JALR2.
  - JALR2=12: A=01, B=10, add; ResultSrc=00; PCWrite=1 → ALUWB.
  - TRAP=13: see Optional Feature.
- **ALU funct decode** (EXECUTER/EXECUTEI):
  - funct3 000: sub only if R-type and Instr[30]=1, otherwise add.
  - funct3 010 slt, 100 xor, 110 or, 111 and.
  - funct3 001/011/101 (shifts, sltu) are unsupported.
- **Branch condition** (funct3):
  - 000 beq: Z; 001 bne: !Z.
  - 100 blt: N^V; 101 bge: !(N^V).
  - 110 bltu: !C; 111 bgeu: C (C=1 means no borrow).
  - 010/011 are unsupported.
- **ImmSrc:** lw, I-ALU, jalr → 000; sw → 001; branch → 010; jal → 011. Unknown opcode → 000.
- **Latency in cycles, including FETCH:** lw 5, sw 4, R/I 4, branch 3, jal 4, jalr 5.
- **Invariants:** at most one of RegWrite/MemWrite per cycle; IRWrite only in FETCH.

Optional Feature:
- Macro: ILLEGAL_TRAP_EN.
- **Defined:**
  - An unknown opcode in DECODE, or an unsupported funct3 in EXECUTER/EXECUTEI/BRANCH, enters TRAP.
  - TRAP holds all write enables at 0 and Illegal=1 until reset. It has no exit other than reset.
- **Undefined:**
  - TRAP is unreachable and Illegal is tied to 0.
  - An unknown opcode in DECODE goes to FETCH (treated as nop).
  - Unsupported ALU funct3 performs add.
  - Unsupported branch funct3 gives taken=0.

Test Plan:
- Hold reset 2 cycles, then release; `Instr`=0x00500093 (addi x1,x0,5) → State 0,1,7,8,0; RegWrite=1 only in ALUWB; PCWrite=1 only in FETCH.
- lw 0x0040A103 → 5 cycles; AdrSrc=1 in MEMREAD; ResultSrc=01 with RegWrite in MEMWB; sw 0x0020A223 → MemWrite=1 for exactly one cycle, in state 5.
- beq 0x00208463 with Z=1 → PCWrite=1 in BRANCH; repeat with Z=0 → PCWrite=0. blt with N=1, V=0 → taken; bltu with C=1 → not taken.
- R-type sub 0x402081B3 → ALUControl=001 in EXECUTER; add 0x002081B3 → 000; and 0x0020F1B3 → 010.
- jal 0x008000EF → State 0,1,10,8, with PCWrite=1 in state 10; jalr 0x000080E7 → 0,1,11,12,8.
- `Instr`=0x0000007F: with ILLEGAL_TRAP_EN → State 13 and Illegal=1, held for 10 cycles until reset; without it → returns to FETCH and Illegal=0. Assert reset during MEMADR → next State=0, and no MemWrite pulse occurs.
